// File: rtl/universal_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load,
// with synchronous preset and clear, and a shift counter that pulses `full`
// each time WIDTH shifts have assembled a complete word.
module universal_shift_reg #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             pre,
   input  logic [1:0]       mode,
   input  logic             sin_r,
   input  logic             sin_l,
   input  logic [WIDTH-1:0] pd,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic             sout_r,
   output logic             sout_l,
   output logic             full
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      MODE_HOLD  = 2'b00,
      MODE_SHR   = 2'b01,
      MODE_SHL   = 2'b10,
      MODE_LOAD  = 2'b11
   } mode_t;

   logic [WIDTH-1:0] r_q;
   logic [CW-1:0]    r_cnt;
   logic             r_full;

   mode_t            w_mode;
   logic             w_cnt_last;
   logic [CW-1:0]    w_cnt_next;

   assign w_mode = mode_t'(mode);

   // Shift bookkeeping shared by both shift directions
   always_comb begin
      w_cnt_last = (r_cnt == CNT_LAST);
      w_cnt_next = w_cnt_last ? '0 : r_cnt + CW'(1);
   end

   // Register update: clear beats preset beats mode
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         r_q    <= '0;
         r_cnt  <= '0;
         r_full <= 1'b0;
      end else if (pre) begin
         r_q    <= '1;
         r_cnt  <= '0;
         r_full <= 1'b0;
      end else begin
         case (w_mode)
            MODE_HOLD: begin
               r_full <= 1'b0;
            end
            MODE_SHR: begin
               r_q    <= {sin_r, r_q[WIDTH-1:1]};
               r_cnt  <= w_cnt_next;
               r_full <= w_cnt_last;
            end
            MODE_SHL: begin
               r_q    <= {r_q[WIDTH-2:0], sin_l};
               r_cnt  <= w_cnt_next;
               r_full <= w_cnt_last;
            end
            default: begin
               r_q    <= pd;
               r_cnt  <= '0;
               r_full <= 1'b0;
            end
         endcase
      end
   end

   // Derived outputs are purely combinational from the register
   always_comb begin
      q      = r_q;
      qbar   = ~r_q;
      sout_r = r_q[0];
      sout_l = r_q[WIDTH-1];
      full   = r_full;
   end

endmodule
